dmem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer for the single-port 256x8 data RAM (sync write, registered read).

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_arbiter_rr_arbiter2.sv | 21 ++
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-RAM arbiter: FSM state encoding and port indices.
package dmem_arb_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_RSP  = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way picker: a lone request wins outright; ties go round-robin or to port 0.
module rr_arbiter2
    import dmem_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_any,
    output logic       winner
);
    assign grant_any = |req;

    always_comb begin
        winner = PORT0;
        if (req == 2'b11)
            winner = (ROUND_ROBIN != 0) ? ~last_grant : PORT0;
        else if (req[1])
            winner = PORT1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the LSU (port 0) and the DMA (port 1).
// One access at a time: IDLE -> ACCESS -> IDLE (write) or -> RD_WAIT -> RD_RSP -> IDLE (read).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [1:0]        state;
    logic              cmd_we;
    logic              cmd_port;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              last_grant;
    logic              grant_any;
    logic              winner;

    rr_arbiter2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .grant_any  (grant_any),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_we     <= 1'b0;
            cmd_port   <= PORT0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            last_grant <= PORT1;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        cmd_port   <= winner;
                        last_grant <= winner;
                        cmd_we     <= (winner == PORT1) ? p1_we    : p0_we;
                        cmd_addr   <= (winner == PORT1) ? p1_addr  : p0_addr;
                        cmd_wdata  <= (winner == PORT1) ? p1_wdata : p0_wdata;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS:  state <= cmd_we ? ST_IDLE : ST_RD_WAIT;
                // RAM output is valid now; load it so rdata lines up with rvalid in RD_RSP.
                ST_RD_WAIT: begin
                    state <= ST_RD_RSP;
                    if (cmd_port == PORT1) p1_rdata <= mem_rdata;
                    else                   p0_rdata <= mem_rdata;
                end
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // All strobes decode from registered state, so they drop the instant reset asserts.
    assign p0_gnt      = (state == ST_ACCESS) && (cmd_port == PORT0);
    assign p1_gnt      = (state == ST_ACCESS) && (cmd_port == PORT1);
    assign p0_rvalid   = (state == ST_RD_RSP) && (cmd_port == PORT0);
    assign p1_rvalid   = (state == ST_RD_RSP) && (cmd_port == PORT1);
    assign mem_we      = (state == ST_ACCESS) && cmd_we;
    assign mem_address = cmd_addr;
    assign mem_wdata   = cmd_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level timeline model and a RAM model.
module tb_dmem_arbiter;
    localparam int NC = 4096;
    localparam int RR = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [7:0] p0_rdata, p1_rdata;
    logic [7:0] mem_address, mem_wdata, mem_rdata;
    logic       mem_we;

    logic       f_req0, f_req1, f_gnt0, f_gnt1, f_rv0, f_rv1, f_mwe;
    logic [7:0] f_rd0, f_rd1, f_maddr, f_mwd;
    logic [7:0] f_mrd = 8'h00;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .ROUND_ROBIN(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f_req0), .p0_we(1'b0), .p0_addr(8'h01), .p0_wdata(8'h00),
        .p0_gnt(f_gnt0), .p0_rvalid(f_rv0), .p0_rdata(f_rd0),
        .p1_req(f_req1), .p1_we(1'b0), .p1_addr(8'h02), .p1_wdata(8'h00),
        .p1_gnt(f_gnt1), .p1_rvalid(f_rv1), .p1_rdata(f_rd1),
        .mem_address(f_maddr), .mem_we(f_mwe), .mem_wdata(f_mwd), .mem_rdata(f_mrd)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM behaviour: synchronous write, registered read.
    logic [7:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_address] <= mem_wdata;
            mem_rdata <= ram[mem_address];
        end
    end

    // Timeline model: each accepted request books its grant, write and read-response cycles.
    int  cyc = 0;
    bit  eg0 [NC], eg1 [NC], erv0 [NC], erv1 [NC], ewe [NC], eav [NC];
    logic [7:0] eaddr [NC], ewd [NC], erd [NC];
    logic [7:0] mem_m [256];
    initial begin
        int k, free_at, pend_k;
        bit last_m, w, pend, wr;
        logic [7:0] a, d, pa, pd;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'(i) ^ 8'h5A;
        last_m = 1'b1; free_at = 0; pend = 1'b0; pend_k = 0; pa = 0; pd = 0;
        forever begin
            @(posedge clk);
            cyc++;
            k = cyc;
            if (!rst_n) begin
                last_m = 1'b1; free_at = 0; pend = 1'b0;
                for (int i = k; i < k + 5 && i < NC; i++) begin
                    eg0[i] = 0; eg1[i] = 0; erv0[i] = 0; erv1[i] = 0; ewe[i] = 0; eav[i] = 0;
                end
            end else begin
                if (pend && pend_k == k - 1) begin mem_m[pa] = pd; pend = 1'b0; end
                if (k >= free_at && (p0_req || p1_req) && k + 3 < NC) begin
                    if (p0_req && p1_req) w = (RR != 0) ? !last_m : 1'b0;
                    else                  w = p1_req;
                    wr = w ? p1_we : p0_we;
                    a  = w ? p1_addr : p0_addr;
                    d  = w ? p1_wdata : p0_wdata;
                    last_m = w;
                    if (w) eg1[k] = 1; else eg0[k] = 1;
                    eav[k] = 1; eaddr[k] = a;
                    if (wr) begin
                        ewe[k] = 1; ewd[k] = d;
                        pend = 1'b1; pend_k = k; pa = a; pd = d;
                        free_at = k + 2;
                    end else begin
                        eav[k+1] = 1; eaddr[k+1] = a;
                        if (w) erv1[k+2] = 1; else erv0[k+2] = 1;
                        erd[k+2] = mem_m[a];
                        free_at = k + 4;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    int gq [$];
    int we_cnt = 0;
    initial begin
        int k;
        logic [7:0] cur0, cur1;
        bit r;
        cur0 = 0; cur1 = 0;
        forever begin
            @(negedge clk);
            k = cyc;
            r = rst_n;
            if (!r) begin cur0 = 0; cur1 = 0; end
            else begin
                if (erv0[k]) cur0 = erd[k];
                if (erv1[k]) cur1 = erd[k];
            end
            chk("p0_gnt",    p0_gnt,    r & eg0[k]);
            chk("p1_gnt",    p1_gnt,    r & eg1[k]);
            chk("p0_rvalid", p0_rvalid, r & erv0[k]);
            chk("p1_rvalid", p1_rvalid, r & erv1[k]);
            chk("mem_we",    mem_we,    r & ewe[k]);
            chk("p0_rdata",  p0_rdata,  cur0);
            chk("p1_rdata",  p1_rdata,  cur1);
            chk("excl_gnt",  p0_gnt & p1_gnt, 0);
            chk("excl_rv",   p0_rvalid & p1_rvalid, 0);
            if (r && eav[k]) chk("mem_address", mem_address, eaddr[k]);
            if (r && ewe[k]) chk("mem_wdata",   mem_wdata,   ewd[k]);
            if (p0_gnt) gq.push_back(0);
            if (p1_gnt) gq.push_back(1);
            if (mem_we) we_cnt++;
        end
    end

    // Called just after a negedge; returns at the negedge of the grant cycle, req still high.
    task automatic req_port(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                            output int gc);
        if (p == 0) begin p0_req = 1; p0_we = w; p0_addr = a; p0_wdata = d; end
        else        begin p1_req = 1; p1_we = w; p1_addr = a; p1_wdata = d; end
        gc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0 && p0_gnt) || (p == 1 && p1_gnt)) begin gc = cyc; break; end
        end
        if (gc < 0) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_rv(input int p, output int rc);
        rc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((p == 0 && p0_rvalid) || (p == 1 && p1_rvalid)) begin rc = cyc; break; end
        end
        if (rc < 0) chk("rvalid_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, rc, q0, w0, c0, c1;
        int gw [4];
        rst_n = 0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        f_req0 = 0; f_req1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_address", mem_address, 0);
        rst_n = 1;
        @(negedge clk);

        // 1: p0 write then read back
        req_port(0, 1'b1, 8'h10, 8'hA5, g);
        req_port(0, 1'b0, 8'h10, 8'h00, g);
        p0_req = 0;
        wait_rv(0, rc);
        chk("t1_rd_latency", rc - g, 2);
        chk("t1_rdata", p0_rdata, 8'hA5);
        repeat (2) @(negedge clk);

        // 2: both ports read continuously; last grant was p0, so p1 leads
        q0 = gq.size();
        fork
            begin
                for (int r = 0; r < 2; r++) req_port(0, 1'b0, 8'h40 + 8'(r), 8'h00, g);
                p0_req = 0;
            end
            begin
                for (int r = 0; r < 2; r++) req_port(1, 1'b0, 8'h50 + 8'(r), 8'h00, g);
                p1_req = 0;
            end
        join
        repeat (6) @(negedge clk);
        chk("t2_count", gq.size() - q0, 4);
        chk("t2_order0", gq[q0],     1);
        chk("t2_order1", gq[q0 + 1], 0);
        chk("t2_order2", gq[q0 + 2], 1);
        chk("t2_order3", gq[q0 + 3], 0);

        // 3: p1 write to 0xFF sampled first, p0 read of 0xFF queued behind it
        q0 = gq.size();
        fork
            begin
                req_port(1, 1'b1, 8'hFF, 8'h3C, g);
                p1_req = 0;
            end
            begin
                @(negedge clk);
                req_port(0, 1'b0, 8'hFF, 8'h00, g);
                p0_req = 0;
                wait_rv(0, rc);
                chk("t3_rdata", p0_rdata, 8'h3C);
            end
        join
        chk("t3_first", gq[q0], 1);
        chk("t3_second", gq[q0 + 1], 0);
        repeat (3) @(negedge clk);

        // 4: reset during the ACCESS cycle of a write aborts it
        p0_req = 1; p0_we = 1; p0_addr = 8'h20; p0_wdata = 8'h77;
        @(posedge clk);
        #1 chk("t4_in_access", p0_gnt, 1);
        #1 rst_n = 0; p0_req = 0;
        #1 chk("t4_gnt_clr", p0_gnt, 0);
        chk("t4_we_clr", mem_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        req_port(0, 1'b0, 8'h20, 8'h00, g);
        p0_req = 0;
        wait_rv(0, rc);
        chk("t4_rdata_prior", p0_rdata, 8'h7A);
        repeat (2) @(negedge clk);

        // 5: back-to-back p1 writes, then read back
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) req_port(1, 1'b1, 8'(i), 8'hC0 + 8'(i), gw[i]);
        p1_req = 0;
        for (int i = 1; i < 4; i++) chk("t5_wr_spacing", gw[i] - gw[i-1], 2);
        repeat (3) @(negedge clk);
        chk("t5_we_cycles", we_cnt - w0, 4);
        for (int i = 0; i < 4; i++) begin
            req_port(1, 1'b0, 8'(i), 8'h00, g);
            p1_req = 0;
            wait_rv(1, rc);
            chk("t5_rdata", p1_rdata, 8'hC0 + i);
        end
        repeat (2) @(negedge clk);

        // 6: fixed priority instance, both reads held for 16 cycles
        f_req0 = 1; f_req1 = 1;
        c0 = 0; c1 = 0;
        repeat (16) begin
            @(negedge clk);
            c0 += int'(f_gnt0);
            c1 += int'(f_gnt1);
        end
        f_req0 = 0; f_req1 = 0;
        chk("t6_fixed_p0_gnts", c0, 4);
        chk("t6_fixed_p1_gnts", c1, 0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
